// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the control-rate tick scheduler and its bus writer:
//   - word addresses of the 16-bit-register interval timer slave
//   - control register bit constants
//   - scheduler state encoding
//   - helper to pick one 16-bit halfword out of a 64-bit period
// -----------------------------------------------------------------------------
package timer_pkg;

    // Timer slave word addresses
    localparam logic [3:0] TMR_STATUS  = 4'd0;
    localparam logic [3:0] TMR_CONTROL = 4'd1;
    localparam logic [3:0] TMR_PERIOD0 = 4'd2;
    localparam logic [3:0] TMR_PERIOD1 = 4'd3;
    localparam logic [3:0] TMR_PERIOD2 = 4'd4;
    localparam logic [3:0] TMR_PERIOD3 = 4'd5;
    localparam logic [3:0] TMR_SNAP0   = 4'd6;
    localparam logic [3:0] TMR_SNAP1   = 4'd7;
    localparam logic [3:0] TMR_SNAP2   = 4'd8;
    localparam logic [3:0] TMR_SNAP3   = 4'd9;

    // Control register bits
    localparam logic [15:0] CTRL_ITO      = 16'h0001;
    localparam logic [15:0] CTRL_CONT     = 16'h0002;
    localparam logic [15:0] CTRL_START    = 16'h0004;
    localparam logic [15:0] CTRL_STOP     = 16'h0008;
    localparam logic [15:0] CTRL_RUN_CONT = CTRL_ITO | CTRL_CONT | CTRL_START;

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_CFG0     = 4'd1,
        ST_CFG1     = 4'd2,
        ST_CFG2     = 4'd3,
        ST_CFG3     = 4'd4,
        ST_CFG_CTRL = 4'd5,
        ST_RUN      = 4'd6,
        ST_ACK      = 4'd7,
        ST_ACK_WAIT = 4'd8,
        ST_STOP     = 4'd9
    } tick_state_t;

    // Halfword k (0 = least significant) of a 64-bit period value.
    function automatic logic [15:0] period_half(input logic [63:0] p,
                                                input logic [1:0]  k);
        logic [5:0] w_lsb;
        w_lsb = {k, 4'b0000};
        return p[w_lsb +: 16];
    endfunction

endpackage

// File: rtl/tmr_bus_writer.sv
// -----------------------------------------------------------------------------
// tmr_bus_writer
// Registered single-cycle write issuer for the timer slave. The slave has no
// waitrequest, so a request presented before a clock edge becomes exactly one
// bus write cycle after that edge; without a request the bus is driven idle
// (chipselect=0, write_n=1, address=0, writedata=0). Reset idles the bus
// asynchronously.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   i_req          in   issue a write in the next cycle
//   i_addr  [3:0]  in   word address for the write
//   i_data  [15:0] in   write data
//   o_address      out  registered timer address
//   o_chipselect   out  registered chipselect
//   o_write_n      out  registered active-low write strobe
//   o_writedata    out  registered write data
// -----------------------------------------------------------------------------
module tmr_bus_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [3:0]  i_addr,
    input  logic [15:0] i_data,
    output logic [3:0]  o_address,
    output logic        o_chipselect,
    output logic        o_write_n,
    output logic [15:0] o_writedata
);

    logic [3:0]  r_address;
    logic        r_chipselect;
    logic        r_write_n;
    logic [15:0] r_writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address    <= 4'd0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= 16'h0000;
        end else if (i_req) begin
            r_address    <= i_addr;
            r_chipselect <= 1'b1;
            r_write_n    <= 1'b0;
            r_writedata  <= i_data;
        end else begin
            r_address    <= 4'd0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= 16'h0000;
        end
    end

    assign o_address    = r_address;
    assign o_chipselect = r_chipselect;
    assign o_write_n    = r_write_n;
    assign o_writedata  = r_writedata;

endmodule

// File: rtl/timer_tick_scheduler.sv
// -----------------------------------------------------------------------------
// timer_tick_scheduler
// Avalon-MM master that owns the interval timer and runs it as the synth's
// control-rate tick source. After reset (and whenever enable rises) it writes
// the 64-bit period and starts continuous interrupt mode; each timeout is
// acknowledged with a status write, producing a one-cycle tick and a wrapping
// tick count. Period changes from the sequencer are latched as pending and
// applied by reprogramming the timer from RUN; dropping enable stops it.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   OFF       | timer stopped, waiting for enable
//   CFG0      | write period halfword 0 (from pending), snapshot pending
//   CFG1..3   | write period halfwords 1..3 (from snapshot)
//   CFG_CTRL  | write ITO|CONT|START to control
//   RUN       | timer running, watching irq / enable / pending period
//   ACK       | write status to clear timeout, tick pulses
//   ACK_WAIT  | bus idle one cycle so the cleared irq is not re-sampled
//   STOP      | write STOP to control
//
// Bus outputs and tick are registered from the next state, so a write and
// its state occupy the same cycle: the first write appears the cycle after
// the decision to program.
//
// Parameters:
//   DEFAULT_PERIOD  load value programmed after reset
//   TICK_W          width of tick_count
//
// Ports:
//   clk, reset                 clock / async active-high reset
//   enable                     level, 1 = timer should run
//   period_in, period_valid    requested load value and its strobe
//   tmr_address/chipselect/write_n/writedata   timer slave write bus
//   tmr_irq                    timer interrupt (level)
//   tick, tick_count           tick pulse and wrapping count
//   busy                       in a programming/ack/stop state
//   active                     timer programmed and started
// -----------------------------------------------------------------------------
module timer_tick_scheduler
    import timer_pkg::*;
#(
    parameter logic [63:0] DEFAULT_PERIOD = 64'h1387F,
    parameter int          TICK_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [63:0]       period_in,
    input  logic              period_valid,
    output logic [3:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic              tmr_irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic              active
);

    tick_state_t       r_state;
    tick_state_t       w_next_state;

    logic [63:0]       r_pending_period;
    logic              r_pending_flag;
    logic [63:0]       r_cur_period;
    logic              r_tick;
    logic [TICK_W-1:0] r_tick_count;

    logic              w_wr_req;
    logic [3:0]        w_wr_addr;
    logic [15:0]       w_wr_data;
    logic              w_load_cfg;
    logic              w_enter_ack;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_OFF: begin
                if (enable) begin
                    w_next_state = ST_CFG0;
                end
            end
            ST_CFG0:     w_next_state = ST_CFG1;
            ST_CFG1:     w_next_state = ST_CFG2;
            ST_CFG2:     w_next_state = ST_CFG3;
            ST_CFG3:     w_next_state = ST_CFG_CTRL;
            ST_CFG_CTRL: w_next_state = ST_RUN;
            ST_RUN: begin
                // A pending timeout always gets its tick before anything else.
                if (tmr_irq) begin
                    w_next_state = ST_ACK;
                end else if (!enable) begin
                    w_next_state = ST_STOP;
                end else if (r_pending_flag) begin
                    w_next_state = ST_CFG0;
                end
            end
            ST_ACK:      w_next_state = ST_ACK_WAIT;
            ST_ACK_WAIT: w_next_state = ST_RUN;
            ST_STOP:     w_next_state = ST_OFF;
            default:     w_next_state = ST_OFF;
        endcase
    end

    // Output logic: bus request for the state being entered
    always_comb begin
        w_wr_req  = 1'b0;
        w_wr_addr = TMR_STATUS;
        w_wr_data = 16'h0000;
        case (w_next_state)
            ST_CFG0: begin
                // Halfword 0 comes straight from pending; the snapshot lands
                // on the same edge and feeds the remaining halfwords.
                w_wr_req  = 1'b1;
                w_wr_addr = TMR_PERIOD0;
                w_wr_data = period_half(r_pending_period, 2'd0);
            end
            ST_CFG1: begin
                w_wr_req  = 1'b1;
                w_wr_addr = TMR_PERIOD1;
                w_wr_data = period_half(r_cur_period, 2'd1);
            end
            ST_CFG2: begin
                w_wr_req  = 1'b1;
                w_wr_addr = TMR_PERIOD2;
                w_wr_data = period_half(r_cur_period, 2'd2);
            end
            ST_CFG3: begin
                w_wr_req  = 1'b1;
                w_wr_addr = TMR_PERIOD3;
                w_wr_data = period_half(r_cur_period, 2'd3);
            end
            ST_CFG_CTRL: begin
                w_wr_req  = 1'b1;
                w_wr_addr = TMR_CONTROL;
                w_wr_data = CTRL_RUN_CONT;
            end
            ST_ACK: begin
                w_wr_req  = 1'b1;
                w_wr_addr = TMR_STATUS;
                w_wr_data = 16'h0000;
            end
            ST_STOP: begin
                w_wr_req  = 1'b1;
                w_wr_addr = TMR_CONTROL;
                w_wr_data = CTRL_STOP;
            end
            default: begin
                w_wr_req  = 1'b0;
            end
        endcase
    end

    // CFG0 is only ever entered from OFF or RUN, so this is a one-cycle event.
    assign w_load_cfg  = (w_next_state == ST_CFG0);
    assign w_enter_ack = (w_next_state == ST_ACK);

    // Pending period: a strobe always re-arms the flag, even on the edge
    // that snapshots, so a late change is applied on the next pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending_period <= DEFAULT_PERIOD;
            r_pending_flag   <= 1'b1;
            r_cur_period     <= 64'd0;
        end else begin
            if (w_load_cfg) begin
                r_cur_period <= r_pending_period;
            end
            if (period_valid) begin
                r_pending_period <= period_in;
                r_pending_flag   <= 1'b1;
            end else if (w_load_cfg) begin
                r_pending_flag   <= 1'b0;
            end
        end
    end

    // Tick aligned with the status write that acknowledges the timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_tick <= w_enter_ack;
            if (w_enter_ack) begin
                r_tick_count <= r_tick_count + {{(TICK_W-1){1'b0}}, 1'b1};
            end
        end
    end

    tmr_bus_writer u_bus_writer (
        .clk          (clk),
        .reset        (reset),
        .i_req        (w_wr_req),
        .i_addr       (w_wr_addr),
        .i_data       (w_wr_data),
        .o_address    (tmr_address),
        .o_chipselect (tmr_chipselect),
        .o_write_n    (tmr_write_n),
        .o_writedata  (tmr_writedata)
    );

    assign tick       = r_tick;
    assign tick_count = r_tick_count;
    assign busy       = (r_state != ST_OFF) && (r_state != ST_RUN);
    assign active     = (r_state == ST_RUN) || (r_state == ST_ACK) ||
                        (r_state == ST_ACK_WAIT);

endmodule

// File: tb/tb_timer_tick_scheduler.sv
module tb_timer_tick_scheduler;

    localparam int TW = 4;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [63:0]   period_in;
    logic          period_valid;
    logic [3:0]    tmr_address;
    logic          tmr_chipselect;
    logic          tmr_write_n;
    logic [15:0]   tmr_writedata;
    logic          tmr_irq;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic          busy;
    logic          active;

    timer_tick_scheduler #(.DEFAULT_PERIOD(64'h1387F), .TICK_W(TW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .period_in      (period_in),
        .period_valid   (period_valid),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq),
        .tick           (tick),
        .tick_count     (tick_count),
        .busy           (busy),
        .active         (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- interval timer model ----------------
    logic [63:0] m_per;
    logic [63:0] m_cnt;
    logic        m_run;
    logic        m_to;
    logic        m_ito;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_per <= 64'd0; m_cnt <= 64'd0; m_run <= 1'b0;
            m_to  <= 1'b0;  m_ito <= 1'b0;
        end else begin
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    4'd0: m_to <= 1'b0;
                    4'd1: begin
                        m_ito <= tmr_writedata[0];
                        if (tmr_writedata[2]) begin m_run <= 1'b1; m_cnt <= m_per; end
                        if (tmr_writedata[3]) m_run <= 1'b0;
                    end
                    4'd2: begin m_per[15:0]  <= tmr_writedata; m_run <= 1'b0; end
                    4'd3: begin m_per[31:16] <= tmr_writedata; m_run <= 1'b0; end
                    4'd4: begin m_per[47:32] <= tmr_writedata; m_run <= 1'b0; end
                    4'd5: begin m_per[63:48] <= tmr_writedata; m_run <= 1'b0; end
                    default: ;
                endcase
            end
            if (m_run && !(tmr_chipselect && !tmr_write_n && tmr_address >= 4'd1 && tmr_address <= 4'd5)) begin
                if (m_cnt == 64'd0) begin m_to <= 1'b1; m_cnt <= m_per; end
                else m_cnt <= m_cnt - 64'd1;
            end
        end
    end
    assign tmr_irq = m_to & m_ito;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_cfg0_cyc = 0;
    logic [19:0]   exp_wr[$];
    logic [TW-1:0] exp_tick[$];
    int            tick_hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [15:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_cfg(input logic [63:0] p);
        push_wr(4'd2, p[15:0]);
        push_wr(4'd3, p[31:16]);
        push_wr(4'd4, p[47:32]);
        push_wr(4'd5, p[63:48]);
        push_wr(4'd1, 16'h0007);
    endtask

    task automatic push_ticks(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            push_wr(4'd0, 16'h0000);
            exp_tick.push_back(TW'(first + i));
        end
    endtask

    // monitor: pops and compares whenever the DUT presents a write or a tick
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (tmr_chipselect && !tmr_write_n) begin
                if (exp_wr.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_write: got %0h:%04h expected none", tmr_address, tmr_writedata);
                end else begin
                    check("bus_write", {44'd0, tmr_address, tmr_writedata}, {44'd0, exp_wr.pop_front()});
                end
                if (tmr_address == 4'd2) last_cfg0_cyc = cyc;
            end
            if (tick) begin
                tick_hist.push_back(cyc);
                check("ack_with_tick", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 4'd0});
                if (exp_tick.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_tick: got count %0d expected no tick", tick_count);
                end else begin
                    check("tick_count", tick_count, exp_tick.pop_front());
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ticks(input int target, input int budget, input string name);
        int k = 0;
        while (tick_hist.size() < target && k < budget) begin @(negedge clk); k++; end
        check(name, tick_hist.size(), target);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_wr.size() != 0 && k < budget) begin @(negedge clk); k++; end
        check(name, exp_wr.size(), 0);
    endtask

    task automatic count_burst(output int n);
        int k = 0;
        n = 0;
        while (!(tmr_chipselect && !tmr_write_n) && k < 100) begin @(negedge clk); k++; end
        while (tmr_chipselect && !tmr_write_n && n < 20) begin n++; @(negedge clk); end
    endtask

    task automatic pulse_period(input logic [63:0] p);
        @(negedge clk);
        period_in = p; period_valid = 1'b1;
        @(negedge clk);
        period_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int k;
        reset = 1'b1; enable = 1'b1; period_in = 64'd0; period_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 4'd0, 16'd0});
        check("rst_outs", {tick, tick_count, busy, active}, 0);

        // S1: default programming, two strobes mid-sequence (last wins)
        push_cfg(64'h1387F);
        push_cfg(64'hAAAA_BBBB_CCCC_DDDD);
        reset = 1'b0;
        k = 0;
        while (!(tmr_chipselect && tmr_address == 4'd2) && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        period_in = 64'h1111_2222_3333_4444; period_valid = 1'b1;
        @(negedge clk);
        period_in = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        period_valid = 1'b0;
        wait_drain(50, "drain_default");
        repeat (2) @(negedge clk);
        check("active_run", {active, busy}, {1'b1, 1'b0});

        // S2: reprogram to 999, three ticks 1000 cycles apart
        push_cfg(64'h3E7);
        push_ticks(1, 3);
        pulse_period(64'h3E7);
        wait_ticks(3, 5000, "ticks_1000");
        check("spacing_1000a", tick_hist[1] - tick_hist[0], 1000);
        check("spacing_1000b", tick_hist[2] - tick_hist[1], 1000);
        check("count_after3", tick_count, 3);

        // S3: irq and period_valid in the same cycle
        push_ticks(4, 1);
        push_cfg(64'h1F3);
        push_ticks(5, 2);
        k = 0;
        while (k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (tmr_irq) break;
        end
        period_in = 64'h1F3; period_valid = 1'b1;
        @(posedge clk); #1;
        period_valid = 1'b0;
        wait_ticks(6, 3000, "ticks_500");
        check("cfg_after_ack", last_cfg0_cyc - tick_hist[3], 3);
        check("spacing_500", tick_hist[5] - tick_hist[4], 500);

        // S4: drop enable
        push_wr(4'd1, 16'h0008);
        @(negedge clk);
        enable = 1'b0;
        repeat (1200) @(negedge clk);
        check("off_state", {active, busy}, 0);
        check("no_tick_off", tick_hist.size(), 6);
        wait_drain(10, "drain_stop");

        // S5: strobes while off (last wins), re-enable, wrap of a 4-bit count
        pulse_period(64'h1234);
        pulse_period(64'h31);
        push_cfg(64'h31);
        push_ticks(7, 11);
        enable = 1'b1;
        count_burst(n);
        check("cfg_burst_len", n, 5);
        wait_ticks(17, 2000, "ticks_50");
        check("count_wrap", tick_count, 1);
        check("spacing_50", tick_hist[16] - tick_hist[15], 50);

        // S6: reset while in CFG2
        push_wr(4'd2, 16'h03E7);
        push_wr(4'd3, 16'h0000);
        push_wr(4'd4, 16'h0000);
        pulse_period(64'h3E7);
        k = 0;
        while (!(tmr_chipselect && !tmr_write_n && tmr_address == 4'd4) && k < 100) begin @(negedge clk); k++; end
        #1 reset = 1'b1;
        #1;
        check("rst_mid_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 4'd0, 16'd0});
        check("rst_mid_outs", {tick_count, busy, active}, 0);
        check("rst_mid_drain", exp_wr.size(), 0);
        push_cfg(64'h1387F);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        count_burst(n);
        check("rst_burst_len", n, 5);
        wait_drain(20, "drain_after_rst");
        repeat (2) @(negedge clk);
        check("active_after_rst", active, 1);
        check("tick_q_empty", exp_tick.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
